// File: rtl/pc_ctrl_pkg.sv
// Shared types and default constants for the fetch PC controller.
// Optional feature: define PC_CTRL_RANGE_CHECK_EN to flag fetches outside
// the instruction-memory window (see pc_ctrl).
package pc_ctrl_pkg;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_PEND = 1'b1
    } pc_state_t;

    localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;
    localparam logic [31:0] PC_EXC_DEFAULT   = 32'h0000_4180;
    localparam logic [31:0] IM_BASE_DEFAULT  = 32'h0000_3000;
    localparam logic [31:0] IM_LIMIT_DEFAULT = 32'h0000_6FFC;
    localparam logic [31:0] PC_STEP          = 32'd4;

    // A fetch address must be word aligned.
    function automatic logic pc_misaligned(input logic [31:0] a);
        return a[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/pc_inc.sv
// Sequential-fetch incrementer: pc + 4, wrapping modulo 2^32.
module pc_inc
    import pc_ctrl_pkg::*;
(
    input  logic [31:0] i_pc,
    output logic [31:0] o_pc_plus4
);

    // Plain 32-bit add; the carry out is dropped so 0xFFFFFFFC wraps to 0.
    always_comb begin
        o_pc_plus4 = i_pc + PC_STEP;
    end

endmodule

// File: rtl/pc_ctrl.sv
// Fetch-stage PC controller: exception entry, eret, branch redirect that can
// be parked while the F stage is stalled, stall hold, and sequential fetch.
// Optional feature: define PC_CTRL_RANGE_CHECK_EN to also raise fetch_exc for
// addresses outside [IM_BASE, IM_LIMIT]; otherwise only misalignment counts.
module pc_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = PC_RESET_DEFAULT,
    parameter logic [31:0] EXC_VEC  = PC_EXC_DEFAULT,
    parameter logic [31:0] IM_BASE  = IM_BASE_DEFAULT,
    parameter logic [31:0] IM_LIMIT = IM_LIMIT_DEFAULT
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        br_take,
    input  logic [31:0] br_target,
    input  logic        exc_req,
    input  logic        eret,
    input  logic [31:0] epc,
    output logic [31:0] pc,
    output logic        pending,
    output logic        fetch_exc
);

    pc_state_t   r_state;
    pc_state_t   w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic [31:0] r_tgt;
    logic [31:0] w_tgt_nxt;
    logic [31:0] w_pc_plus4;
    logic        w_misaligned;
    logic        w_out_of_range;

    pc_inc u_pc_inc (
        .i_pc       (r_pc),
        .o_pc_plus4 (w_pc_plus4)
    );

    // State, pc and parked-target registers; reset discards any parked redirect.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_RUN;
            r_pc    <= RESET_PC;
            r_tgt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_tgt   <= w_tgt_nxt;
        end
    end

    // Next-pc selection: exception > eret > redirect > stall hold > pc+4.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_tgt_nxt   = r_tgt;
        if (exc_req) begin
            w_pc_nxt    = EXC_VEC;
            w_state_nxt = ST_RUN;
        end else if (eret) begin
            w_pc_nxt    = epc;
            w_state_nxt = ST_RUN;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (br_take) begin
                        if (stall) begin
                            w_tgt_nxt   = br_target;
                            w_state_nxt = ST_PEND;
                        end else begin
                            w_pc_nxt    = br_target;
                        end
                    end else if (!stall) begin
                        w_pc_nxt = w_pc_plus4;
                    end
                end
                ST_PEND: begin
                    if (stall) begin
                        // A newer resolved branch supersedes the parked one.
                        if (br_take) begin
                            w_tgt_nxt = br_target;
                        end
                    end else begin
                        w_pc_nxt    = br_take ? br_target : r_tgt;
                        w_state_nxt = ST_RUN;
                    end
                end
                default: begin
                    w_state_nxt = ST_RUN;
                end
            endcase
        end
    end

    // Address-error detection on the current fetch address.
    always_comb begin
        w_misaligned = pc_misaligned(r_pc);
`ifdef PC_CTRL_RANGE_CHECK_EN
        w_out_of_range = (r_pc < IM_BASE) || (r_pc > IM_LIMIT);
`else
        w_out_of_range = 1'b0;
`endif
    end

    assign pc        = r_pc;
    assign pending   = (r_state == ST_PEND);
    assign fetch_exc = w_misaligned | w_out_of_range;

endmodule
